// File: rtl/fare_card_responder_if.sv
// fare_card_responder_if
//   Bundle of the tap, programming and response signals between the gate side (master) and the
//   card responder (slave). clk and rst_n are plain ports on the modules, not part of the bundle.
//   Optional macro CONCESSION_EN adds prog_concession.
//   master: drives nfc, card_id, maintenance, reduce_bal, prog_*; samples the responses.
//   slave : samples the requests; drives card_active, fund_enough, resp_valid, busy,
//           balance_out, deduct_err.
interface fare_card_responder_if #(
   parameter int unsigned ID_W  = 4,
   parameter int unsigned BAL_W = 16
);
   logic             nfc;
   logic [ID_W-1:0]  card_id;
   logic             maintenance;
   logic             reduce_bal;
   logic             prog_we;
   logic [ID_W-1:0]  prog_id;
   logic             prog_active;
   logic [BAL_W-1:0] prog_bal;
`ifdef CONCESSION_EN
   logic             prog_concession;
`endif
   logic             card_active;
   logic             fund_enough;
   logic             resp_valid;
   logic             busy;
   logic [BAL_W-1:0] balance_out;
   logic             deduct_err;

   modport master (
      output nfc, card_id, maintenance, reduce_bal, prog_we, prog_id, prog_active, prog_bal,
`ifdef CONCESSION_EN
      output prog_concession,
`endif
      input  card_active, fund_enough, resp_valid, busy, balance_out, deduct_err
   );

   modport slave (
      input  nfc, card_id, maintenance, reduce_bal, prog_we, prog_id, prog_active, prog_bal,
`ifdef CONCESSION_EN
      input  prog_concession,
`endif
      output card_active, fund_enough, resp_valid, busy, balance_out, deduct_err
   );
endinterface

// File: rtl/fare_card_responder.sv
// fare_card_responder
//   Card-side responder for the gate FSM. A tap (nfc) looks the card up in a programmable table
//   and reports card_active/fund_enough; a reduce_bal pulse while the response is held deducts
//   the fare. Optional macro CONCESSION_EN adds a per-card concession bit (half fare).
//   Ports: clk, rst_n (async active-low); bus (slave modport of fare_card_responder_if) carrying
//   nfc/card_id/maintenance/reduce_bal/prog_* in and card_active/fund_enough/resp_valid/busy/
//   balance_out/deduct_err out.
module fare_card_responder #(
   parameter int unsigned NUM_CARDS   = 16,
   parameter int unsigned ID_W        = 4,
   parameter int unsigned BAL_W       = 16,
   parameter int unsigned FARE        = 250,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   fare_card_responder_if.slave bus
);
   localparam int unsigned LatW  = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [BAL_W-1:0] FareVal = BAL_W'(FARE);

   typedef enum logic [1:0] {StIdle, StLookup, StRespond, StDeduct} state_e;

   state_e state_q, state_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [LatW-1:0]  lat_q, lat_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             card_active_q, card_active_d;
   logic             fund_q, fund_d;
   logic             valid_q, valid_d;
   logic [BAL_W-1:0] bal_out_q, bal_out_d;
   logic             err_q, err_d;

   logic             active_q [NUM_CARDS];
   logic [BAL_W-1:0] bal_q    [NUM_CARDS];
`ifdef CONCESSION_EN
   logic             conc_q   [NUM_CARDS];
`endif

   logic             id_ok, prog_ok, ded_we;
   logic             cur_active;
   logic [BAL_W-1:0] cur_bal, cur_fare, ded_val;

   // Out-of-range ids read as an inactive card with zero balance.
   assign id_ok      = 32'(id_q) < NUM_CARDS;
   assign prog_ok    = 32'(bus.prog_id) < NUM_CARDS;
   assign cur_active = id_ok ? active_q[id_q] : 1'b0;
   assign cur_bal    = id_ok ? bal_q[id_q] : '0;
`ifdef CONCESSION_EN
   assign cur_fare   = (id_ok && conc_q[id_q]) ? (FareVal >> 1) : FareVal;
`else
   assign cur_fare   = FareVal;
`endif
   assign ded_val    = cur_bal - cur_fare;

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      lat_d         = lat_q;
      hold_d        = hold_q;
      card_active_d = card_active_q;
      fund_d        = fund_q;
      valid_d       = valid_q;
      bal_out_d     = bal_out_q;
      err_d         = 1'b0;
      ded_we        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.nfc && !bus.maintenance) begin
               id_d    = bus.card_id;
               lat_d   = LatW'(LATENCY);
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (bus.maintenance) begin
               state_d = StIdle;
               bal_out_d = '0;
            end else if (lat_q == LatW'(1)) begin
               card_active_d = cur_active;
               fund_d        = cur_active && (cur_bal >= cur_fare);
               bal_out_d     = cur_bal;
               valid_d       = 1'b1;
               hold_d        = HoldW'(HOLD_CYCLES);
               state_d       = StRespond;
            end else begin
               lat_d = lat_q - LatW'(1);
            end
         end
         StRespond: begin
            // Abort beats reduce_bal; reduce_bal beats timeout.
            if (bus.maintenance) begin
               state_d   = StIdle;
               bal_out_d = '0;
            end else if (bus.reduce_bal) begin
               if (fund_q) begin
                  state_d = StDeduct;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end else if (hold_q == HoldW'(1)) begin
               state_d = StIdle;
            end else begin
               hold_d = hold_q - HoldW'(1);
            end
         end
         StDeduct: begin
            state_d = StIdle;
            if (bus.maintenance) begin
               bal_out_d = '0;
            end else if (bus.prog_we && (bus.prog_id == id_q)) begin
               // Concurrent table write to this card wins; deduction is dropped.
               err_d = 1'b1;
            end else begin
               ded_we    = 1'b1;
               bal_out_d = ded_val;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StIdle) begin
         card_active_d = 1'b0;
         fund_d        = 1'b0;
         valid_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         id_q          <= '0;
         lat_q         <= '0;
         hold_q        <= '0;
         card_active_q <= 1'b0;
         fund_q        <= 1'b0;
         valid_q       <= 1'b0;
         bal_out_q     <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         id_q          <= id_d;
         lat_q         <= lat_d;
         hold_q        <= hold_d;
         card_active_q <= card_active_d;
         fund_q        <= fund_d;
         valid_q       <= valid_d;
         bal_out_q     <= bal_out_d;
         err_q         <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_CARDS); i++) begin
            active_q[i] <= 1'b0;
            bal_q[i]    <= '0;
`ifdef CONCESSION_EN
            conc_q[i]   <= 1'b0;
`endif
         end
      end else begin
         if (ded_we) begin
            bal_q[id_q] <= ded_val;
         end
         if (bus.prog_we && prog_ok) begin
            active_q[bus.prog_id] <= bus.prog_active;
            bal_q[bus.prog_id]    <= bus.prog_bal;
`ifdef CONCESSION_EN
            conc_q[bus.prog_id]   <= bus.prog_concession;
`endif
         end
      end
   end

   assign bus.card_active = card_active_q;
   assign bus.fund_enough = fund_q;
   assign bus.resp_valid  = valid_q;
   assign bus.busy        = (state_q != StIdle);
   assign bus.balance_out = bal_out_q;
   assign bus.deduct_err  = err_q;
endmodule

// File: tb/tb_fare_card_responder.sv
// tb_fare_card_responder
//   Directed bench for fare_card_responder. Inputs change and outputs are sampled on the falling
//   clock edge. Build with +define+CONCESSION_EN to exercise the concession path.
module tb_fare_card_responder;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   hi_cnt;

   fare_card_responder_if #(.ID_W(4), .BAL_W(16)) bus ();

   fare_card_responder #(
      .NUM_CARDS(16), .ID_W(4), .BAL_W(16), .FARE(250), .LATENCY(1), .HOLD_CYCLES(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic program_card(input logic [3:0] id, input logic act, input logic [15:0] bal,
                               input logic conc);
      bus.prog_we     = 1'b1;
      bus.prog_id     = id;
      bus.prog_active = act;
      bus.prog_bal    = bal;
`ifdef CONCESSION_EN
      bus.prog_concession = conc;
`else
      if (conc) $display("note: concession ignored in this build");
`endif
      tick();
      bus.prog_we = 1'b0;
   endtask

   // Leaves the bench one falling edge after the capture edge (DUT in lookup).
   task automatic tap(input logic [3:0] id);
      bus.nfc     = 1'b1;
      bus.card_id = id;
      tick();
      bus.nfc = 1'b0;
   endtask

   task automatic pulse_reduce();
      bus.reduce_bal = 1'b1;
      tick();
      bus.reduce_bal = 1'b0;
   endtask

   task automatic abort();
      bus.maintenance = 1'b1;
      tick();
      bus.maintenance = 1'b0;
   endtask

   // Reads a table entry back through a tap, then aborts the response.
   task automatic peek(input string tag, input logic [3:0] id, input logic [15:0] bal,
                       input logic act);
      tap(id);
      tick();
      check({tag, "_valid"}, 32'(bus.resp_valid), 1);
      check({tag, "_bal"}, 32'(bus.balance_out), 32'(bal));
      check({tag, "_active"}, 32'(bus.card_active), 32'(act));
      abort();
      check({tag, "_idle"}, 32'(bus.busy), 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.nfc = 1'b0;
      bus.card_id = '0;
      bus.maintenance = 1'b0;
      bus.reduce_bal = 1'b0;
      bus.prog_we = 1'b0;
      bus.prog_id = '0;
      bus.prog_active = 1'b0;
      bus.prog_bal = '0;
`ifdef CONCESSION_EN
      bus.prog_concession = 1'b0;
`endif
      tick();
      tick();
      check("rst_valid", 32'(bus.resp_valid), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_active", 32'(bus.card_active), 0);
      check("rst_fund", 32'(bus.fund_enough), 0);
      check("rst_bal", 32'(bus.balance_out), 0);
      check("rst_err", 32'(bus.deduct_err), 0);
      rst_n = 1'b1;
      tick();

      // 1: normal pass, 1000 -> 750
      program_card(4'd3, 1'b1, 16'd1000, 1'b0);
      tap(4'd3);
      check("t1_busy", 32'(bus.busy), 1);
      check("t1_early", 32'(bus.resp_valid), 0);
      tick();
      check("t1_valid", 32'(bus.resp_valid), 1);
      check("t1_active", 32'(bus.card_active), 1);
      check("t1_fund", 32'(bus.fund_enough), 1);
      check("t1_bal_pre", 32'(bus.balance_out), 1000);
      pulse_reduce();
      check("t1_deduct_busy", 32'(bus.busy), 1);
      tick();
      check("t1_bal_post", 32'(bus.balance_out), 750);
      check("t1_done_valid", 32'(bus.resp_valid), 0);
      check("t1_done_busy", 32'(bus.busy), 0);
      check("t1_no_err", 32'(bus.deduct_err), 0);
      peek("t1_tbl", 4'd3, 16'd750, 1'b1);

      // reduce_bal while idle is ignored
      pulse_reduce();
      check("idle_reduce_err", 32'(bus.deduct_err), 0);
      check("idle_reduce_busy", 32'(bus.busy), 0);

      // 2: inactive card rejects deduction
      program_card(4'd5, 1'b0, 16'd500, 1'b0);
      tap(4'd5);
      tick();
      check("t2_active", 32'(bus.card_active), 0);
      check("t2_fund", 32'(bus.fund_enough), 0);
      pulse_reduce();
      check("t2_err", 32'(bus.deduct_err), 1);
      check("t2_idle", 32'(bus.busy), 0);
      tick();
      check("t2_err_clr", 32'(bus.deduct_err), 0);
      peek("t2_tbl", 4'd5, 16'd500, 1'b0);

      // 3: fare boundary
      program_card(4'd3, 1'b1, 16'd249, 1'b0);
      tap(4'd3);
      tick();
      check("t3_fund_249", 32'(bus.fund_enough), 0);
      abort();
      program_card(4'd3, 1'b1, 16'd250, 1'b0);
      tap(4'd3);
      tick();
      check("t3_fund_250", 32'(bus.fund_enough), 1);
      pulse_reduce();
      tick();
      check("t3_bal_zero", 32'(bus.balance_out), 0);

      // 4: maintenance
      bus.maintenance = 1'b1;
      tap(4'd3);
      check("t4_maint_tap", 32'(bus.busy), 0);
      tick();
      check("t4_maint_valid", 32'(bus.resp_valid), 0);
      bus.maintenance = 1'b0;
      program_card(4'd3, 1'b1, 16'd1000, 1'b0);
      tap(4'd3);
      tick();
      check("t4_valid", 32'(bus.resp_valid), 1);
      bus.maintenance = 1'b1;
      bus.reduce_bal = 1'b1;
      tick();
      bus.maintenance = 1'b0;
      bus.reduce_bal = 1'b0;
      check("t4_abort_busy", 32'(bus.busy), 0);
      check("t4_abort_valid", 32'(bus.resp_valid), 0);
      check("t4_abort_err", 32'(bus.deduct_err), 0);
      peek("t4_tbl", 4'd3, 16'd1000, 1'b1);

      // 5: timeout after 8 cycles, second tap ignored
      tap(4'd3);
      tick();
      hi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus.resp_valid) break;
         hi_cnt++;
         bus.nfc = (i == 3);
         bus.card_id = 4'd5;
         tick();
      end
      bus.nfc = 1'b0;
      check("t5_hold", 32'(hi_cnt), 8);
      check("t5_idle", 32'(bus.busy), 0);
      tick();
      check("t5_no_queue", 32'(bus.busy), 0);
      peek("t5_tbl", 4'd3, 16'd1000, 1'b1);

      // Table write on the deduct cycle wins and flags the drop
      tap(4'd3);
      tick();
      pulse_reduce();
      program_card(4'd3, 1'b1, 16'd777, 1'b0);
      check("wr_deduct_err", 32'(bus.deduct_err), 1);
      peek("wr_tbl", 4'd3, 16'd777, 1'b1);

      // 6: concession card, 125 cents
      program_card(4'd2, 1'b1, 16'd125, 1'b1);
      tap(4'd2);
      tick();
`ifdef CONCESSION_EN
      check("t6_conc_fund", 32'(bus.fund_enough), 1);
      pulse_reduce();
      tick();
      check("t6_conc_bal", 32'(bus.balance_out), 0);
`else
      check("t6_full_fund", 32'(bus.fund_enough), 0);
      abort();
`endif

      // Asynchronous reset in the middle of a lookup
      tap(4'd3);
      check("rst_mid_busy_pre", 32'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(bus.busy), 0);
      check("rst_mid_valid", 32'(bus.resp_valid), 0);
      check("rst_mid_bal", 32'(bus.balance_out), 0);
      tick();
      rst_n = 1'b1;
      tick();
      peek("rst_tbl", 4'd3, 16'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
